// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl
//   Multicycle shift-add multiply sequencer that owns the architectural HI/LO
//   register pair. Accepts MULTU/MULT/MTHI/MTLO from decode, runs an
//   N-iteration multiply, then writes the full 2N-bit product to {hi, lo} in a
//   single fix-up cycle so partial products never become visible.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     command valid, sampled on the rising edge
//   op        00 MULTU, 01 MULT (signed), 10 MTHI, 11 MTLO
//   a         multiplicand / MTHI-MTLO source
//   b         multiplier
//   busy      multiply in progress (RUN or FIX); new commands are ignored
//   done      one-cycle pulse, hi/lo hold the new product
//   hi, lo    architectural HI and LO
//   rd_req    MFHI/MFLO present in decode
//   rd_sel    1 selects HI, 0 selects LO
//   rd_data   combinational read of the selected register
//   rd_stall  read collides with an in-flight multiply
module hilo_mdu_ctrl #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    input  logic         rd_req,
    input  logic         rd_sel,
    output logic [N-1:0] rd_data,
    output logic         rd_stall
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OpMultu = 2'b00;
    localparam logic [1:0] OpMult  = 2'b01;
    localparam logic [1:0] OpMthi  = 2'b10;
    localparam logic [1:0] OpMtlo  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    state_e          state_q;
    logic [N-1:0]    hi_q;
    logic [N-1:0]    lo_q;
    logic            busy_q;
    logic            done_q;
    logic [CntW-1:0] cnt_q;
    // One guard bit above the 2N-bit product catches the carry of each add
    // before the right shift brings it back into range.
    logic [2*N:0]    acc_q;
    logic [N-1:0]    mcand_q;
    logic [N-1:0]    mplier_q;
    logic            neg_q;

    logic            is_signed;
    logic [N-1:0]    a_abs;
    logic [N-1:0]    b_abs;
    logic [N:0]      acc_sum;
    logic [2*N:0]    acc_add;
    logic [2*N:0]    acc_nxt;
    logic [2*N-1:0]  product;
    logic            last_iter;

    always_comb begin
        is_signed = (op == OpMult);
        // Magnitude of the most-negative value is representable as unsigned N.
        a_abs     = (is_signed && a[N-1]) ? -a : a;
        b_abs     = (is_signed && b[N-1]) ? -b : b;

        acc_sum   = acc_q[2*N:N] + {1'b0, mcand_q};
        acc_add   = mplier_q[0] ? {acc_sum, acc_q[N-1:0]} : acc_q;
        acc_nxt   = acc_add >> 1;

        product   = neg_q ? -acc_q[2*N-1:0] : acc_q[2*N-1:0];
        last_iter = (cnt_q == CntW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    if (start) begin
                        case (op)
                            OpMthi: hi_q <= a;
                            OpMtlo: lo_q <= a;
                            default: begin
                                // OpMultu / OpMult
                                mcand_q  <= a_abs;
                                mplier_q <= b_abs;
                                neg_q    <= is_signed & (a[N-1] ^ b[N-1]);
                                acc_q    <= '0;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= StRun;
                            end
                        endcase
                    end
                end
                StRun: begin
                    acc_q    <= acc_nxt;
                    mplier_q <= mplier_q >> 1;
                    if (last_iter) begin
                        cnt_q   <= '0;
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFix: begin
                    {hi_q, lo_q} <= product;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    // During a multiply this still shows the old HI/LO; readers must stall.
    assign rd_data  = rd_sel ? hi_q : lo_q;
    assign rd_stall = rd_req & busy_q;

    // OpMultu only appears through the default arm of the command decode.
    logic unused_op;
    assign unused_op = (OpMultu == 2'b00);

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl with a product scoreboard.
module tb_hilo_mdu_ctrl;

    localparam int unsigned N = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic          rd_req;
    logic          rd_sel;
    logic [N-1:0]  rd_data;
    logic          rd_stall;

    int unsigned   vectors;
    int unsigned   miscompares;
    logic [63:0]   exp_q[$];
    logic [31:0]   hi_m;
    logic [31:0]   lo_m;

    hilo_mdu_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_stall (rd_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model_mul(input logic [1:0] op_v, input logic [31:0] av,
                                              input logic [31:0] bv);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (op_v == 2'b01) begin
            sa = {{32{av[31]}}, av};
            sb = {{32{bv[31]}}, bv};
            return sa * sb;
        end
        return {32'b0, av} * {32'b0, bv};
    endfunction

    // Drive a multiply command at the current (negedge) time and queue its result.
    task automatic issue_mul(input logic [1:0] op_v, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = op_v;
        a     = av;
        b     = bv;
        exp_q.push_back(model_mul(op_v, av, bv));
    endtask

    // j counts edges after the start edge; done is due at j == 33.
    task automatic wait_done(input string tag, input int inject_at, input bit chk_rd);
        int j;
        int busy_cnt;
        logic [63:0] e;
        j = 0;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && j < 200) begin
            if (busy) busy_cnt++;
            check({tag, "_hi_hold"}, 64'(hi), 64'(hi_m));
            check({tag, "_lo_hold"}, 64'(lo), 64'(lo_m));
            if (chk_rd) begin
                check({tag, "_rd_stall"}, 64'(rd_stall), 64'(j <= 32));
                check({tag, "_rd_data"}, 64'(rd_data), 64'(rd_sel ? hi_m : lo_m));
            end
            if (inject_at >= 0 && j == inject_at) begin
                start = 1'b1;
                op    = 2'b11;
                a     = 32'h0000_DEAD;
            end else if (inject_at >= 0 && j == inject_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        check({tag, "_latency"}, 64'(j), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        if (chk_rd) check({tag, "_rd_stall_done"}, 64'(rd_stall), 64'd0);
        check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            hi_m = e[63:32];
            lo_m = e[31:0];
        end
        check({tag, "_hi"}, 64'(hi), 64'(hi_m));
        check({tag, "_lo"}, 64'(lo), 64'(lo_m));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hi_m        = '0;
        lo_m        = '0;
        rst_n       = 1'b0;
        start       = 1'b0;
        op          = 2'b00;
        a           = '0;
        b           = '0;
        rd_req      = 1'b0;
        rd_sel      = 1'b0;

        // Reset state
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_stall", 64'(rd_stall), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Small unsigned multiply, latency and busy width
        @(negedge clk);
        issue_mul(2'b00, 32'h0001_0003, 32'h0000_0002);
        wait_done("multu_small", -1, 1'b0);
        check("multu_small_lo_const", 64'(lo), 64'h0002_0006);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);

        // Boundary products
        @(negedge clk);
        issue_mul(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", -1, 1'b0);
        check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        @(negedge clk);
        issue_mul(2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done("mult_neg3x5", -1, 1'b0);
        check("mult_neg3x5_lo_const", 64'(lo), 64'hFFFF_FFF1);
        @(negedge clk);
        issue_mul(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minxmin", -1, 1'b0);
        check("mult_minxmin_hi_const", 64'(hi), 64'h4000_0000);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(lo), 64'(lo_m));
        check("mthi_no_done", 64'(done), 64'd0);
        hi_m = 32'h1234_5678;
        op   = 2'b11;
        a    = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        lo_m  = 32'h9ABC_DEF0;
        check("mtlo_lo", 64'(lo), 64'(lo_m));
        check("mtlo_hi_kept", 64'(hi), 64'(hi_m));
        check("mtlo_no_done", 64'(done), 64'd0);
        rd_sel = 1'b1;
        #1;
        check("rd_hi", 64'(rd_data), 64'h1234_5678);
        rd_sel = 1'b0;
        #1;
        check("rd_lo", 64'(rd_data), 64'h9ABC_DEF0);
        @(negedge clk);
        check("mt_no_done_later", 64'(done), 64'd0);

        // Command while busy is ignored; read stall tracks busy
        rd_req = 1'b1;
        issue_mul(2'b00, 32'd7, 32'd6);
        wait_done("ignore_busy", 4, 1'b1);
        check("ignore_busy_lo_const", 64'(lo), 64'd42);
        check("ignore_busy_hi_const", 64'(hi), 64'd0);
        rd_req = 1'b0;

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        issue_mul(2'b00, 32'd5, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        exp_q.delete();
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("post_rst_no_done", 64'(done), 64'd0);
        end
        issue_mul(2'b00, 32'd3, 32'd3);
        wait_done("after_rst", -1, 1'b0);
        check("after_rst_lo_const", 64'(lo), 64'd9);

        // Back-to-back: new start accepted in the DONE cycle
        @(negedge clk);
        issue_mul(2'b00, 32'd3, 32'd4);
        wait_done("b2b_first", -1, 1'b0);
        check("b2b_first_lo_const", 64'(lo), 64'd12);
        issue_mul(2'b00, 32'd2, 32'd2);
        wait_done("b2b_second", -1, 1'b0);
        check("b2b_second_lo_const", 64'(lo), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
